// File: rtl/li_relay_station.sv
// li_relay_station: two-entry latency-insensitive relay station.
// A registered ready/valid stage that breaks the combinational ready path and
// the data path between two LI shells. It keeps full throughput without
// bubbles by parking one extra word in a skid register (aux_q).
// The word is opaque. Bit 0 is the sample-valid flag by convention, and it
// passes through like any other bit.
// Optional feature: define RELAY_STATS_EN to add saturating delivery/stall
// counters and their ports (o_xfer_count, o_stall_count).

module li_relay_station #(
  parameter int DATA_WIDTH  = 0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  input  logic                   i_ready
`ifdef RELAY_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_xfer_count,
  output logic [COUNT_WIDTH-1:0] o_stall_count
`endif
);

  // A word must carry at least the flag bit plus one payload bit.
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("li_relay_station: DATA_WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] aux_q;
  logic                  accept;
  logic                  deliver;

  // Outputs are decodes of the state register only. i_ready therefore never
  // reaches o_ready. Gating with reset keeps o_ready low while reset is held.
  assign o_valid = (state != EMPTY);
  assign o_ready = (state != FULL) && reset;
  assign o_data  = main_q;

  assign accept  = i_valid && o_ready;
  assign deliver = o_valid && i_ready;

  // State machine and storage. main_q always holds the oldest word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      aux_q  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= i_data;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_q <= i_data;
          end else if (accept) begin
            aux_q <= i_data;
            state <= FULL;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_q <= aux_q;
            state  <= BUSY;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef RELAY_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CountMax = {COUNT_WIDTH{1'b1}};

  logic [COUNT_WIDTH-1:0] xfer_q;
  logic [COUNT_WIDTH-1:0] stall_q;

  assign o_xfer_count  = xfer_q;
  assign o_stall_count = stall_q;

  // Saturating statistics: delivered words, and cycles stalled by downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (deliver && (xfer_q != CountMax)) begin
        xfer_q <= xfer_q + CountOne;
      end
      if (o_valid && !i_ready && (stall_q != CountMax)) begin
        stall_q <= stall_q + CountOne;
      end
    end
  end
`endif

endmodule
